// File: rtl/i2c_pkg.sv
// Types and constants shared by the I2C slave receive front end, controller and SDA output select.
package i2c_pkg;

   localparam int BITS_PER_BYTE = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_ADDR,
      RX_DATA,
      RX_ACK,
      RX_DISCARD
   } rx_state_t;

   // Encodings of sda_mode, driven by the controller into the SDA output select.
   localparam logic [1:0] SDA_MODE_IDLE = 2'b00;
   localparam logic [1:0] SDA_MODE_ACK  = 2'b01;
   localparam logic [1:0] SDA_MODE_NACK = 2'b10;
   localparam logic [1:0] SDA_MODE_TX   = 2'b11;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one open-drain pad, with a history flop for edge pulses.
module i2c_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic pad_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;

   // Idle bus is high, so resetting to 1 avoids a spurious edge after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= pad_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~s3_q;
   assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/i2c_rx_front.sv
// I2C slave receive front end: START/STOP detection, byte shifting, address check, ACK sampling.
module i2c_rx_front
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_rise,
   output logic       scl_fall,
   output logic       start_found,
   output logic       stop_found,
   output logic       address_match,
   output logic       rw_mode,
   output logic       byte_received,
   output logic [7:0] rx_data,
   output logic       ack_slot,
   output logic       ack_valid,
   output logic       ack_bit
);

   localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

   logic scl_lvl, scl_r, scl_f;
   logic sda_lvl, sda_r, sda_f;

   i2c_sync_edge u_scl (.clk(clk), .rst(rst), .pad_i(scl_in),
                        .level_o(scl_lvl), .rise_o(scl_r), .fall_o(scl_f));
   i2c_sync_edge u_sda (.clk(clk), .rst(rst), .pad_i(sda_in),
                        .level_o(sda_lvl), .rise_o(sda_r), .fall_o(sda_f));

   // SCL must be high both before and after the SDA edge, so an SDA change
   // coinciding with an SCL transition is never taken as START or STOP.
   logic scl_high;
   assign scl_high    = scl_lvl & ~scl_r;
   assign start_found = sda_f & scl_high;
   assign stop_found  = sda_r & scl_high;
   assign scl_rise    = scl_r;
   assign scl_fall    = scl_f;

   rx_state_t  state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] rx_q, rx_d;
   logic       rw_q, rw_d;
   logic       slot_q, slot_d;
   logic       ackb_q, ackb_d;
   logic       am_q, am_d;
   logic       br_q, br_d;
   logic       av_q, av_d;
   logic [7:0] byte_w;

   assign byte_w = {shift_q[6:0], sda_lvl};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      rw_d    = rw_q;
      slot_d  = slot_q;
      ackb_d  = ackb_q;
      am_d    = 1'b0;
      br_d    = 1'b0;
      av_d    = 1'b0;
      if (start_found) begin
         state_d = RX_ADDR;
         cnt_d   = '0;
         slot_d  = 1'b0;
      end else if (stop_found) begin
         state_d = RX_IDLE;
         slot_d  = 1'b0;
      end else begin
         case (state_q)
            RX_ADDR, RX_DATA: begin
               if (scl_r) begin
                  shift_d = byte_w;
                  cnt_d   = cnt_q + 3'd1;
                  if (cnt_q == LAST_BIT) begin
                     rx_d = byte_w;
                     if (state_q == RX_DATA) begin
                        br_d    = 1'b1;
                        state_d = RX_ACK;
                     end else if (byte_w[7:1] == SLAVE_ADDR) begin
                        am_d    = 1'b1;
                        rw_d    = byte_w[0];
                        state_d = RX_ACK;
                     end else begin
                        state_d = RX_DISCARD;
                     end
                  end
               end
            end
            // Entered on the 8th rise: the next fall opens the slot, the one after closes it.
            RX_ACK: begin
               if (scl_f) begin
                  if (!slot_q) begin
                     slot_d = 1'b1;
                  end else begin
                     slot_d  = 1'b0;
                     state_d = RX_DATA;
                     cnt_d   = '0;
                  end
               end else if (scl_r && slot_q) begin
                  ackb_d = sda_lvl;
                  av_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         rx_q    <= '0;
         rw_q    <= 1'b0;
         slot_q  <= 1'b0;
         ackb_q  <= 1'b1;
         am_q    <= 1'b0;
         br_q    <= 1'b0;
         av_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
         rw_q    <= rw_d;
         slot_q  <= slot_d;
         ackb_q  <= ackb_d;
         am_q    <= am_d;
         br_q    <= br_d;
         av_q    <= av_d;
      end
   end

   assign address_match = am_q;
   assign rw_mode       = rw_q;
   assign byte_received = br_q;
   assign rx_data       = rx_q;
   assign ack_slot      = slot_q;
   assign ack_valid     = av_q;
   assign ack_bit       = ackb_q;

endmodule
